// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared types and default widths for the dmem_arbiter block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    REQ_CPU = 1'b0,
    REQ_VID = 1'b1
  } req_id_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_pick.sv
// ============================================================================
// Module   : dmem_arb_pick
// Purpose  : Combinational winner select between the CPU and video requesters.
//            DMEM_ARB_ROUND_ROBIN_EN selects the round-robin tie-break;
//            otherwise the CPU wins every tie.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic    cpu_req,
  input  logic    vid_req,
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  input  req_id_t prio_ptr,
`endif
  output logic    valid,
  output req_id_t winner
);

  always_comb begin
    valid  = cpu_req | vid_req;
    winner = REQ_CPU;
    if (cpu_req && vid_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      // prio_ptr names the requester that did not win the previous grant
      winner = prio_ptr;
`else
      winner = REQ_CPU;
`endif
    end else if (vid_req) begin
      winner = REQ_VID;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port arbiter/sequencer for the single-port data memory.
//            Define DMEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
//            the default build uses fixed CPU priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              vid_req,
  input  logic              vid_we,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [DATA_W-1:0] vid_wdata,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,

  output logic              MemRead,
  output logic              MemWrite,
  output logic [31:0]       ALUResult,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] readData,

  output logic              busy
);

  state_t            state;
  state_t            state_nxt;
  req_id_t           owner;
  req_id_t           winner;
  logic              pick_valid;
  logic              grant;
  logic              complete_rd;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  req_id_t prio_ptr;

  dmem_arb_pick u_pick (
    .cpu_req  (cpu_req),
    .vid_req  (vid_req),
    .prio_ptr (prio_ptr),
    .valid    (pick_valid),
    .winner   (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_ptr <= REQ_CPU;
    end else if (grant) begin
      prio_ptr <= (winner == REQ_CPU) ? REQ_VID : REQ_CPU;
    end
  end
`else
  dmem_arb_pick u_pick (
    .cpu_req  (cpu_req),
    .vid_req  (vid_req),
    .valid    (pick_valid),
    .winner   (winner)
  );
`endif

  assign sel_we    = (winner == REQ_VID) ? vid_we    : cpu_we;
  assign sel_addr  = (winner == REQ_VID) ? vid_addr  : cpu_addr;
  assign sel_wdata = (winner == REQ_VID) ? vid_wdata : cpu_wdata;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    complete_rd = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        complete_rd = MemRead;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= REQ_CPU;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      ALUResult  <= '0;
      writeData  <= '0;
      cpu_gnt    <= 1'b0;
      vid_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      vid_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      vid_rdata  <= '0;
    end else begin
      cpu_gnt    <= grant && (winner == REQ_CPU);
      vid_gnt    <= grant && (winner == REQ_VID);
      cpu_rvalid <= complete_rd && (owner == REQ_CPU);
      vid_rvalid <= complete_rd && (owner == REQ_VID);
      if (grant) begin
        owner     <= winner;
        MemRead   <= !sel_we;
        MemWrite  <= sel_we;
        ALUResult <= {{(32-ADDR_W){1'b0}}, sel_addr};
        writeData <= sel_wdata;
      end else if (state == ISSUE) begin
        MemRead  <= 1'b0;
        MemWrite <= 1'b0;
      end
      // readData is valid only at the ISSUE->IDLE edge, after the falling-edge access
      if (complete_rd && (owner == REQ_CPU)) cpu_rdata <= readData;
      if (complete_rd && (owner == REQ_VID)) vid_rdata <= readData;
    end
  end

endmodule

`default_nettype wire
